// File: rtl/jam_pkg.sv
// Shared definitions for the JAM cost-lookup server.
//   N_JOB      workers = jobs (fixed by the 3-bit W/J lookup interface)
//   COST_W     width of one cost entry
//   MINCOST_W  width of the JAM engine's MinCost result
//   MATCH_W    width of the JAM engine's MatchCount result
//   IDX_W      width of the flat row-major load index {W,J}
//   state_t    server FSM states
package jam_pkg;
  localparam int N_JOB     = 8;
  localparam int COST_W    = 7;
  localparam int MINCOST_W = 10;
  localparam int MATCH_W   = 4;
  localparam int IDX_W     = 6;
  localparam int N_ENTRY   = N_JOB * N_JOB;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SERVE = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/jam_cost_ram.sv
// 64-entry cost table with one flat write port and a registered 2-D read port.
//   CLK, RST  clock, asynchronous active-high reset (clears every entry and the read register)
//   we        write enable
//   waddr     flat write address {W,J}
//   wdata     cost entry to write
//   W, J      read coordinates
//   rdata     table[W][J], registered every posedge
module jam_cost_ram
  import jam_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [COST_W-1:0] wdata,
  input  logic [2:0]        W,
  input  logic [2:0]        J,
  output logic [COST_W-1:0] rdata
);

  logic [COST_W-1:0] mem [N_ENTRY];

  // A write and a read of the same entry in one cycle returns the old value.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < N_ENTRY; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[{W, J}];
    end
  end

endmodule

// File: rtl/jam_cost_server.sv
// Responder side of the JAM cost-lookup interface. Loads an 8x8 cost matrix over a
// valid/ready stream, holds the JAM engine in reset until the matrix is complete, serves
// (W,J) lookups with a registered Cost, and captures the engine's result on Valid.
//   CLK, RST         clock, asynchronous active-high reset
//   start            begin a new load (honoured in IDLE or DONE only)
//   load_valid/ready load stream handshake; load_data is the next row-major entry
//   jam_rst          registered reset to the JAM engine, low only while serving
//   W, J, Cost       lookup request and registered table[W][J]
//   Valid, MinCost, MatchCount  engine completion and result
//   table_loaded     all 64 entries written since the last start
//   done, res_*      captured result
//   serve_cycles     cycles spent in SERVE, saturating
//   fsm_state        current FSM state (debug)
//
// Load handshake: an entry transfers at a posedge where load_valid and load_ready are both
// high. load_ready is registered and never depends on load_valid; load_valid without
// load_ready is simply ignored.
module jam_cost_server
  import jam_pkg::*;
#(
  parameter int ACC_W = 20
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [COST_W-1:0]    load_data,
  output logic                 jam_rst,
  input  logic [2:0]           W,
  input  logic [2:0]           J,
  output logic [COST_W-1:0]    Cost,
  input  logic                 Valid,
  input  logic [MINCOST_W-1:0] MinCost,
  input  logic [MATCH_W-1:0]   MatchCount,
  output logic                 table_loaded,
  output logic                 done,
  output logic [MINCOST_W-1:0] res_min_cost,
  output logic [MATCH_W-1:0]   res_match_count,
  output logic [ACC_W-1:0]     serve_cycles,
  output state_t               fsm_state
);

  state_t             state_q;
  state_t             next_state;
  logic [IDX_W-1:0]   idx;
  logic               handshake;
  logic               last_entry;
  logic               enter_load;
  logic               capture;

  assign handshake  = load_valid & load_ready;
  assign last_entry = handshake && (idx == IDX_W'(N_ENTRY - 1));
  assign enter_load = start && ((state_q == IDLE) || (state_q == DONE));
  assign capture    = (state_q == SERVE) && Valid;
  assign fsm_state  = state_q;

  always_comb begin
    next_state = state_q;
    case (state_q)
      IDLE:    if (start)      next_state = LOAD;
      LOAD:    if (last_entry) next_state = SERVE;
      SERVE:   if (Valid)      next_state = DONE;
      DONE:    if (start)      next_state = LOAD;
      default:                 next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q         <= IDLE;
      load_ready      <= 1'b0;
      jam_rst         <= 1'b1;
      idx             <= '0;
      table_loaded    <= 1'b0;
      done            <= 1'b0;
      res_min_cost    <= '0;
      res_match_count <= '0;
      serve_cycles    <= '0;
    end else begin
      state_q <= next_state;
      // Ready comes up one cycle after LOAD is entered and drops with the final handshake.
      load_ready <= (state_q == LOAD) && (next_state == LOAD);
      // Derived from the registered state so the engine leaves reset one cycle after
      // SERVE is entered, and goes back into reset one cycle after the result is taken.
      jam_rst <= (state_q != SERVE);
      if (enter_load) begin
        idx             <= '0;
        table_loaded    <= 1'b0;
        done            <= 1'b0;
        res_min_cost    <= '0;
        res_match_count <= '0;
        serve_cycles    <= '0;
      end else begin
        if (handshake)  idx <= idx + 1'b1;
        if (last_entry) table_loaded <= 1'b1;
        if (capture) begin
          res_min_cost    <= MinCost;
          res_match_count <= MatchCount;
          done            <= 1'b1;
        end
        if ((state_q == SERVE) && (serve_cycles != '1))
          serve_cycles <= serve_cycles + 1'b1;
      end
    end
  end

  jam_cost_ram u_ram (
    .CLK   (CLK),
    .RST   (RST),
    .we    (handshake),
    .waddr (idx),
    .wdata (load_data),
    .W     (W),
    .J     (J),
    .rdata (Cost)
  );

endmodule

// File: tb/tb_jam_cost_server.sv
// Bench for jam_cost_server: table-driven lookups, randomized matrices, a behavioural JAM
// engine that reads the whole table through the Cost port and solves the assignment with a
// bitmask dynamic program, and hand-written multi-cycle corner cases.
module tb_jam_cost_server;
  import jam_pkg::*;

  logic                 CLK = 1'b0;
  logic                 RST;
  logic                 start;
  logic                 load_valid;
  logic                 load_ready;
  logic [COST_W-1:0]    load_data;
  logic                 jam_rst;
  logic [2:0]           W;
  logic [2:0]           J;
  logic [COST_W-1:0]    Cost;
  logic                 Valid;
  logic [MINCOST_W-1:0] MinCost;
  logic [MATCH_W-1:0]   MatchCount;
  logic                 table_loaded;
  logic                 done;
  logic [MINCOST_W-1:0] res_min_cost;
  logic [MATCH_W-1:0]   res_match_count;
  logic [19:0]          serve_cycles;
  state_t               fsm_state;

  jam_cost_server #(.ACC_W(20)) dut (
    .CLK             (CLK),
    .RST             (RST),
    .start           (start),
    .load_valid      (load_valid),
    .load_ready      (load_ready),
    .load_data       (load_data),
    .jam_rst         (jam_rst),
    .W               (W),
    .J               (J),
    .Cost            (Cost),
    .Valid           (Valid),
    .MinCost         (MinCost),
    .MatchCount      (MatchCount),
    .table_loaded    (table_loaded),
    .done            (done),
    .res_min_cost    (res_min_cost),
    .res_match_count (res_match_count),
    .serve_cycles    (serve_cycles),
    .fsm_state       (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int mat [64];
  logic [COST_W-1:0] exp_q [$];

  typedef struct {
    int w;
    int j;
    int cost;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  // Optimal assignment cost and number of optimal assignments (saturated to 4 bits).
  function automatic void golden(input int m [64], output int mc, output int cnt);
    int best [256];
    int ways [256];
    int w, nm, c;
    for (int k = 0; k < 256; k++) begin
      best[k] = 1 << 30;
      ways[k] = 0;
    end
    best[0] = 0;
    ways[0] = 1;
    for (int mask = 0; mask < 255; mask++) begin
      if (best[mask] < (1 << 30)) begin
        w = $countones(mask);
        for (int j = 0; j < 8; j++) begin
          if (((mask >> j) & 1) == 0) begin
            nm = mask | (1 << j);
            c  = best[mask] + m[w * 8 + j];
            if (c < best[nm]) begin
              best[nm] = c;
              ways[nm] = ways[mask];
            end else if (c == best[nm]) begin
              ways[nm] = ways[nm] + ways[mask];
            end
          end
        end
      end
    end
    mc  = best[255];
    cnt = (ways[255] > 15) ? 15 : ways[255];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  // Offers mat[] entries, load_valid on 1 cycle out of every 'period', until 'limit'
  // handshakes are seen. Returns with load_valid low, one negedge after the last handshake.
  task automatic do_load(input int period, input int limit, output int first_hs,
                         output int last_hs);
    int sent = 0;
    int cyc  = 0;
    first_hs = -1;
    last_hs  = -1;
    while (sent < limit && cyc < 1000) begin
      @(negedge CLK);
      load_valid = ((cyc % period) == 0);
      load_data  = COST_W'(mat[sent]);
      if (load_valid && load_ready) begin
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        sent++;
      end
      cyc++;
    end
    chk("load_count", sent, limit);
    @(negedge CLK);
    load_valid = 1'b0;
  endtask

  task automatic rd(input int w, input int j, output int c);
    W = 3'(w);
    J = 3'(j);
    @(negedge CLK);
    c = int'(Cost);
  endtask

  // Behavioural JAM engine: waits for release from reset, reads all 64 costs through the
  // lookup port, solves the assignment, reports via Valid. len = posedges spent in SERVE.
  task automatic run_engine(output int len);
    int guard = 0;
    int rm [64];
    int emin, ecnt;
    len = 0;
    while (jam_rst && guard < 10) begin
      @(negedge CLK);
      guard++;
    end
    chk("jam_rst_release", int'(jam_rst), 0);
    if (!jam_rst) begin
      len = 1;
      for (int i = 0; i < 64; i++) exp_q.push_back(COST_W'(mat[i]));
      for (int i = 0; i < 64; i++) begin
        W = 3'(i / 8);
        J = 3'(i % 8);
        @(negedge CLK);
        len++;
        rm[i] = int'(Cost);
        chk("engine_read", rm[i], int'(exp_q.pop_front()));
      end
      golden(rm, emin, ecnt);
      MinCost    = MINCOST_W'(emin);
      MatchCount = MATCH_W'(ecnt);
      Valid      = 1'b1;
      @(negedge CLK);
      len++;
      Valid = 1'b0;
    end
  endtask

  task automatic check_result(input string tag);
    int gmin, gcnt;
    golden(mat, gmin, gcnt);
    chk({tag, "_done"}, int'(done), 1);
    chk({tag, "_min_cost"}, int'(res_min_cost), gmin);
    chk({tag, "_match_count"}, int'(res_match_count), gcnt);
    chk({tag, "_state"}, int'(fsm_state), int'(DONE));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int fh, lh, c, len, r1, r2, diff;

    vecs[0] = '{w: 5, j: 3, cost: 43};
    vecs[1] = '{w: 0, j: 0, cost: 0};
    vecs[2] = '{w: 7, j: 7, cost: 63};
    vecs[3] = '{w: 3, j: 4, cost: 28};
    vecs[4] = '{w: 1, j: 6, cost: 14};
    vecs[5] = '{w: 6, j: 1, cost: 49};

    RST = 1'b1; start = 1'b0; load_valid = 1'b0; load_data = '0;
    W = '0; J = '0; Valid = 1'b0; MinCost = '0; MatchCount = '0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;

    // 1: reset then idle
    repeat (3) @(negedge CLK);
    chk("idle_load_ready", int'(load_ready), 0);
    chk("idle_jam_rst", int'(jam_rst), 1);
    chk("idle_state", int'(fsm_state), int'(IDLE));
    chk("idle_table_loaded", int'(table_loaded), 0);
    chk("idle_serve_cycles", int'(serve_cycles), 0);
    for (int k = 0; k < 4; k++) begin
      rd($urandom_range(0, 7), $urandom_range(0, 7), c);
      chk("idle_cost", c, 0);
    end
    MinCost = 10'd5; MatchCount = 4'd3; Valid = 1'b1;
    @(negedge CLK);
    Valid = 1'b0;
    @(negedge CLK);
    chk("idle_valid_done", int'(done), 0);
    chk("idle_valid_res", int'(res_min_cost), 0);
    chk("idle_valid_state", int'(fsm_state), int'(IDLE));

    // 2: full-rate load of w*8+j
    for (int i = 0; i < 64; i++) mat[i] = i;
    pulse_start();
    chk("load_state", int'(fsm_state), int'(LOAD));
    do_load(1, 64, fh, lh);
    chk("load_64_cycles", lh - fh, 63);
    chk("loaded_flag", int'(table_loaded), 1);
    chk("loaded_ready_low", int'(load_ready), 0);
    chk("loaded_state", int'(fsm_state), int'(SERVE));
    chk("serve_entry_jam_rst", int'(jam_rst), 1);
    @(negedge CLK);
    chk("serve_jam_rst_low", int'(jam_rst), 0);
    for (int k = 0; k < 6; k++) begin
      rd(vecs[k].w, vecs[k].j, c);
      chk("vec_cost", c, vecs[k].cost);
    end
    for (int k = 0; k < 16; k++) begin
      r1 = $urandom_range(0, 7);
      r2 = $urandom_range(0, 7);
      rd(r1, r2, c);
      chk("rand_cost", c, mat[r1 * 8 + r2]);
    end
    // 5b: start during SERVE is ignored
    pulse_start();
    chk("serve_start_state", int'(fsm_state), int'(SERVE));
    chk("serve_start_loaded", int'(table_loaded), 1);
    chk("serve_start_ready", int'(load_ready), 0);
    r1 = $urandom_range(0, 1023);
    r2 = $urandom_range(0, 15);
    MinCost = 10'(r1); MatchCount = 4'(r2); Valid = 1'b1;
    @(negedge CLK);
    Valid = 1'b0;
    chk("capture_done", int'(done), 1);
    chk("capture_min", int'(res_min_cost), r1);
    chk("capture_cnt", int'(res_match_count), r2);
    chk("capture_state", int'(fsm_state), int'(DONE));
    @(negedge CLK);
    chk("done_jam_rst", int'(jam_rst), 1);
    MinCost = 10'(r1 ^ 1); Valid = 1'b1;
    @(negedge CLK);
    Valid = 1'b0;
    chk("done_hold_min", int'(res_min_cost), r1);

    // 3: throttled load of a random matrix, then spurious load_valid
    for (int i = 0; i < 64; i++) mat[i] = $urandom_range(0, 127);
    pulse_start();
    do_load(3, 64, fh, lh);
    chk("thr_loaded", int'(table_loaded), 1);
    for (int k = 0; k < 5; k++) begin
      load_valid = 1'b1;
      load_data  = 7'h7f;
      chk("thr_extra_ready", int'(load_ready), 0);
      @(negedge CLK);
    end
    load_valid = 1'b0;
    run_engine(len);
    check_result("thr");

    // 4: identity-cost matrix
    for (int i = 0; i < 64; i++) mat[i] = ((i / 8) == (i % 8)) ? 0 : 100;
    pulse_start();
    do_load(1, 64, fh, lh);
    run_engine(len);
    check_result("ident");
    chk("ident_min_const", int'(res_min_cost), 0);
    chk("ident_cnt_const", int'(res_match_count), 1);
    diff = int'(serve_cycles) - len;
    checks++;
    if (diff > 1 || diff < -1) begin
      errors++;
      $display("FAIL ident_serve_cycles actual %0d required %0d+-1", serve_cycles, len);
    end

    // 6: restart from DONE with an all-7 matrix
    for (int i = 0; i < 64; i++) mat[i] = 7;
    pulse_start();
    chk("restart_done_clear", int'(done), 0);
    chk("restart_res_clear", int'(res_min_cost), 0);
    chk("restart_serve_clear", int'(serve_cycles), 0);
    chk("restart_loaded_clear", int'(table_loaded), 0);
    do_load(1, 64, fh, lh);
    run_engine(len);
    check_result("all7");
    chk("all7_min_const", int'(res_min_cost), 56);
    chk("all7_cnt_const", int'(res_match_count), 15);
    diff = int'(serve_cycles) - len;
    checks++;
    if (diff > 1 || diff < -1) begin
      errors++;
      $display("FAIL all7_serve_cycles actual %0d required %0d+-1", serve_cycles, len);
    end

    // 5: reset after 30 loads
    for (int i = 0; i < 64; i++) mat[i] = 64 + i;
    pulse_start();
    do_load(1, 30, fh, lh);
    chk("midload_state", int'(fsm_state), int'(LOAD));
    RST = 1'b1;
    #1;
    chk("rst_jam_rst", int'(jam_rst), 1);
    chk("rst_ready", int'(load_ready), 0);
    chk("rst_state", int'(fsm_state), int'(IDLE));
    chk("rst_cost", int'(Cost), 0);
    @(negedge CLK);
    RST = 1'b0;
    for (int k = 0; k < 30; k += 7) begin
      rd(k / 8, k % 8, c);
      chk("rst_table_zero", c, 0);
    end
    chk("rst_loaded", int'(table_loaded), 0);
    // A fresh load must start again at entry 0.
    mat[0] = 99;
    pulse_start();
    do_load(1, 1, fh, lh);
    rd(0, 0, c);
    chk("reload_entry0", c, 99);
    rd(0, 1, c);
    chk("reload_entry1", c, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
